// File: rtl/sorter_pkg.sv
// Shared types and default sizing for the bottom-K MinHash sorter.
package sorter_pkg;

  localparam int unsigned DEF_SIGNATURE_WIDTH = 32;
  localparam int unsigned DEF_INDEX_WIDTH     = 10;
  localparam int unsigned DEF_NUM_SLOTS       = 8;
  localparam int unsigned DEF_LOG_SLOTS       = 3;
  localparam int unsigned DEF_DEDUP           = 1;

  typedef enum logic {
    COLLECT = 1'b0,
    DRAIN   = 1'b1
  } state_t;

  typedef struct packed {
    logic                           valid;
    logic [DEF_SIGNATURE_WIDTH-1:0] signature;
    logic [DEF_INDEX_WIDTH-1:0]     index;
  } slot_t;

endpackage

// File: rtl/sorter_slot.sv
// One entry of the insertion shift array: loads the input, takes its lower
// neighbour on a shift, and flags how the incoming signature compares to it.
module sorter_slot
  import sorter_pkg::*;
#(
  parameter int unsigned SIGNATURE_WIDTH = DEF_SIGNATURE_WIDTH,
  parameter int unsigned INDEX_WIDTH     = DEF_INDEX_WIDTH
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       clear,
  input  logic                       load,
  input  logic                       shift,
  input  logic [SIGNATURE_WIDTH-1:0] in_signature,
  input  logic [INDEX_WIDTH-1:0]     in_index,
  input  logic                       prev_valid,
  input  logic [SIGNATURE_WIDTH-1:0] prev_signature,
  input  logic [INDEX_WIDTH-1:0]     prev_index,
  output logic                       valid,
  output logic [SIGNATURE_WIDTH-1:0] signature,
  output logic [INDEX_WIDTH-1:0]     index,
  output logic                       less,
  output logic                       equal
);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      valid     <= 1'b0;
      signature <= '0;
      index     <= '0;
    end else if (clear) begin
      valid <= 1'b0;
    end else if (load) begin
      valid     <= 1'b1;
      signature <= in_signature;
      index     <= in_index;
    end else if (shift) begin
      valid     <= prev_valid;
      signature <= prev_signature;
      index     <= prev_index;
    end
  end

  always_comb begin
    less  = !valid || (in_signature < signature);
    equal = valid && (in_signature == signature);
  end

endmodule

// File: rtl/bottomk_sorter_v3.sv
// Bottom-K signature sorter: keeps the NUM_SLOTS smallest signatures of a frame
// in ascending order, then drains them through a valid/ready port.
module bottomk_sorter_v3
  import sorter_pkg::*;
#(
  parameter int unsigned SIGNATURE_WIDTH = DEF_SIGNATURE_WIDTH,
  parameter int unsigned INDEX_WIDTH     = DEF_INDEX_WIDTH,
  parameter int unsigned NUM_SLOTS       = DEF_NUM_SLOTS,
  parameter int unsigned LOG_SLOTS       = DEF_LOG_SLOTS,
  parameter int unsigned DEDUP           = DEF_DEDUP
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [SIGNATURE_WIDTH-1:0] in_signature,
  input  logic [INDEX_WIDTH-1:0]     in_index,
  input  logic                       in_last,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [SIGNATURE_WIDTH-1:0] out_signature,
  output logic [INDEX_WIDTH-1:0]     out_index,
  output logic                       out_last,
  output logic [LOG_SLOTS:0]         count
);

  localparam int unsigned CW = LOG_SLOTS + 1;

  state_t state;
  logic [CW-1:0] rd;
  logic [CW-1:0] rd_nxt;
  logic [CW-1:0] count_nxt;

  logic                       slot_valid [NUM_SLOTS];
  logic [SIGNATURE_WIDTH-1:0] slot_sig   [NUM_SLOTS];
  logic [INDEX_WIDTH-1:0]     slot_idx   [NUM_SLOTS];
  logic [NUM_SLOTS-1:0]       lt;
  logic [NUM_SLOTS-1:0]       eq;
  logic [NUM_SLOTS-1:0]       load;
  logic [NUM_SLOTS-1:0]       shift;

  logic accept;
  logic dup;
  logic do_insert;
  logic clear;
  logic [SIGNATURE_WIDTH-1:0] head_sig;
  logic [INDEX_WIDTH-1:0]     head_idx;
  logic [SIGNATURE_WIDTH-1:0] drain_sig;
  logic [INDEX_WIDTH-1:0]     drain_idx;

  for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_slot
    logic                       pv;
    logic [SIGNATURE_WIDTH-1:0] ps;
    logic [INDEX_WIDTH-1:0]     pi;
    if (g == 0) begin : g_head
      assign pv = 1'b0;
      assign ps = '0;
      assign pi = '0;
    end else begin : g_body
      assign pv = slot_valid[g-1];
      assign ps = slot_sig[g-1];
      assign pi = slot_idx[g-1];
    end

    sorter_slot #(
      .SIGNATURE_WIDTH(SIGNATURE_WIDTH),
      .INDEX_WIDTH    (INDEX_WIDTH)
    ) u_slot (
      .clock         (clock),
      .reset         (reset),
      .clear         (clear),
      .load          (load[g]),
      .shift         (shift[g]),
      .in_signature  (in_signature),
      .in_index      (in_index),
      .prev_valid    (pv),
      .prev_signature(ps),
      .prev_index    (pi),
      .valid         (slot_valid[g]),
      .signature     (slot_sig[g]),
      .index         (slot_idx[g]),
      .less          (lt[g]),
      .equal         (eq[g])
    );
  end

  // First qualifying slot takes the input; every slot above it shifts up.
  always_comb begin
    logic seen;
    seen      = 1'b0;
    load      = '0;
    shift     = '0;
    accept    = in_valid && in_ready;
    dup       = (DEDUP != 0) && (|eq);
    do_insert = accept && !dup && (|lt);
    for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
      load[i]  = do_insert && lt[i] && !seen;
      shift[i] = do_insert && seen;
      seen     = seen | lt[i];
    end
  end

  always_comb begin
    count_nxt = count;
    if (do_insert && (count != CW'(NUM_SLOTS)))
      count_nxt = count + CW'(1);
    head_sig = load[0] ? in_signature : slot_sig[0];
    head_idx = load[0] ? in_index     : slot_idx[0];
    rd_nxt   = rd + CW'(1);
    clear    = (state == DRAIN) && out_valid && out_ready && out_last;
  end

  always_comb begin
    drain_sig = '0;
    drain_idx = '0;
    for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
      if (rd_nxt == CW'(i)) begin
        drain_sig = slot_sig[i];
        drain_idx = slot_idx[i];
      end
    end
  end

  // Entering DRAIN presents the post-insertion head so slot[0] is visible on
  // the first DRAIN cycle; later beats preload slot[rd+1] on each handshake.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state         <= COLLECT;
      count         <= '0;
      rd            <= '0;
      in_ready      <= 1'b1;
      out_valid     <= 1'b0;
      out_last      <= 1'b0;
      out_signature <= '0;
      out_index     <= '0;
    end else begin
      case (state)
        COLLECT: begin
          count <= count_nxt;
          if (accept && in_last) begin
            state         <= DRAIN;
            in_ready      <= 1'b0;
            rd            <= '0;
            out_valid     <= 1'b1;
            out_last      <= (count_nxt == CW'(1));
            out_signature <= head_sig;
            out_index     <= head_idx;
          end
        end
        DRAIN: begin
          if (out_valid && out_ready) begin
            if (out_last) begin
              state     <= COLLECT;
              count     <= '0;
              rd        <= '0;
              in_ready  <= 1'b1;
              out_valid <= 1'b0;
              out_last  <= 1'b0;
            end else begin
              rd            <= rd_nxt;
              out_last      <= (rd_nxt == count - CW'(1));
              out_signature <= drain_sig;
              out_index     <= drain_idx;
            end
          end
        end
        default: state <= COLLECT;
      endcase
    end
  end

endmodule

// File: tb/tb_bottomk_sorter_v3.sv
// Scoreboard bench: a DEDUP=1 and a DEDUP=0 sorter share stimulus; drain beats
// are checked against hand-computed expectations queued per instance.
module tb_bottomk_sorter_v3;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_signature = '0;
  logic [9:0]  in_index = '0;
  logic        in_last = 1'b0;
  logic        out_ready = 1'b0;

  logic        ir [2];
  logic        ov [2];
  logic        ol [2];
  logic [31:0] os [2];
  logic [9:0]  oi [2];
  logic [3:0]  cnt [2];

  typedef struct {
    logic [31:0] sig;
    logic [9:0]  idx;
    logic        last;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  int n_cmp = 0;
  int n_bad = 0;

  logic        held [2];
  logic [31:0] hs [2];
  logic [9:0]  hi [2];

  always #5 clock = ~clock;

  bottomk_sorter_v3 #(
    .SIGNATURE_WIDTH(32), .INDEX_WIDTH(10), .NUM_SLOTS(8), .LOG_SLOTS(3), .DEDUP(1)
  ) dut_dd (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(ir[0]), .in_signature(in_signature),
    .in_index(in_index), .in_last(in_last),
    .out_valid(ov[0]), .out_ready(out_ready), .out_signature(os[0]),
    .out_index(oi[0]), .out_last(ol[0]), .count(cnt[0])
  );

  bottomk_sorter_v3 #(
    .SIGNATURE_WIDTH(32), .INDEX_WIDTH(10), .NUM_SLOTS(8), .LOG_SLOTS(3), .DEDUP(0)
  ) dut_nd (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(ir[1]), .in_signature(in_signature),
    .in_index(in_index), .in_last(in_last),
    .out_valid(ov[1]), .out_ready(out_ready), .out_signature(os[1]),
    .out_index(oi[1]), .out_last(ol[1]), .count(cnt[1])
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input int u, input logic [31:0] s, input logic [9:0] i, input logic l);
    exp_t e;
    e.sig = s; e.idx = i; e.last = l;
    if (u == 0) q0.push_back(e);
    else        q1.push_back(e);
  endtask

  task automatic push_both(input logic [31:0] s, input logic [9:0] i, input logic l);
    push(0, s, i, l);
    push(1, s, i, l);
  endtask

  task automatic mon(input int u);
    exp_t e;
    int   qs;
    if (held[u]) begin
      chk($sformatf("u%0d_hold_valid", u), 64'(ov[u]), 64'd1);
      chk($sformatf("u%0d_hold_sig", u), 64'(os[u]), 64'(hs[u]));
      chk($sformatf("u%0d_hold_idx", u), 64'(oi[u]), 64'(hi[u]));
    end
    if (ov[u] && out_ready) begin
      qs = (u == 0) ? q0.size() : q1.size();
      if (qs == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL u%0d_extra_beat: got idx 0x%0h expected no beat", u, oi[u]);
      end else begin
        if (u == 0) e = q0.pop_front();
        else        e = q1.pop_front();
        chk($sformatf("u%0d_drain_sig", u), 64'(os[u]), 64'(e.sig));
        chk($sformatf("u%0d_drain_idx", u), 64'(oi[u]), 64'(e.idx));
        chk($sformatf("u%0d_drain_last", u), 64'(ol[u]), 64'(e.last));
      end
    end
    held[u] = ov[u] && !out_ready;
    hs[u]   = os[u];
    hi[u]   = oi[u];
  endtask

  always @(negedge clock) begin
    for (int u = 0; u < 2; u++) begin
      if (!reset) held[u] = 1'b0;
      else        mon(u);
    end
  end

  task automatic send(input logic [31:0] s, input logic [9:0] i, input logic l);
    in_valid = 1'b1; in_signature = s; in_index = i; in_last = l;
    chk("u0_in_ready", 64'(ir[0]), 64'd1);
    chk("u1_in_ready", 64'(ir[1]), 64'd1);
    @(posedge clock); #1;
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic check_count(input logic [3:0] e0, input logic [3:0] e1);
    chk("u0_count", 64'(cnt[0]), 64'(e0));
    chk("u1_count", 64'(cnt[1]), 64'(e1));
  endtask

  task automatic drain_all();
    bit done;
    done = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 40 && !done; c++) begin
      @(posedge clock); #1;
      done = (q0.size() == 0) && (q1.size() == 0) && ir[0] && ir[1];
    end
    chk("drain_complete", 64'(done), 64'd1);
    chk("u0_idle_valid", 64'(ov[0]), 64'd0);
    chk("u1_idle_valid", 64'(ov[1]), 64'd0);
    check_count(4'd0, 4'd0);
    out_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] t1_sig [9];
    t1_sig = '{32'h10, 32'h08, 32'h20, 32'h05, 32'h15, 32'h25, 32'h35, 32'h45, 32'h55};

    repeat (2) @(posedge clock); #1;
    for (int u = 0; u < 2; u++) begin
      chk($sformatf("u%0d_rst_count", u), 64'(cnt[u]), 64'd0);
      chk($sformatf("u%0d_rst_valid", u), 64'(ov[u]), 64'd0);
      chk($sformatf("u%0d_rst_last", u), 64'(ol[u]), 64'd0);
      chk($sformatf("u%0d_rst_sig", u), 64'(os[u]), 64'd0);
      chk($sformatf("u%0d_rst_idx", u), 64'(oi[u]), 64'd0);
    end
    @(negedge clock) reset = 1'b1;
    @(posedge clock); #1;

    // Full frame: ninth beat is larger than all kept and falls off the end.
    push_both(32'h05, 10'd4, 1'b0);
    push_both(32'h08, 10'd2, 1'b0);
    push_both(32'h10, 10'd1, 1'b0);
    push_both(32'h15, 10'd5, 1'b0);
    push_both(32'h20, 10'd3, 1'b0);
    push_both(32'h25, 10'd6, 1'b0);
    push_both(32'h35, 10'd7, 1'b0);
    push_both(32'h45, 10'd8, 1'b1);
    for (int k = 0; k < 9; k++) send(t1_sig[k], 10'(k + 1), k == 8);
    check_count(4'd8, 4'd8);
    chk("u0_drain_starts", 64'(ov[0]), 64'd1);
    drain_all();

    // Short frame.
    push_both(32'h10, 10'd2, 1'b0);
    push_both(32'h20, 10'd3, 1'b0);
    push_both(32'h30, 10'd1, 1'b1);
    send(32'h30, 10'd1, 1'b0);
    send(32'h10, 10'd2, 1'b0);
    send(32'h20, 10'd3, 1'b1);
    check_count(4'd3, 4'd3);
    drain_all();

    // Duplicate signature: dropped with DEDUP=1, kept behind the earlier one otherwise.
    push(0, 32'h08, 10'd3, 1'b0);
    push(0, 32'h10, 10'd1, 1'b1);
    push(1, 32'h08, 10'd3, 1'b0);
    push(1, 32'h10, 10'd1, 1'b0);
    push(1, 32'h10, 10'd2, 1'b1);
    send(32'h10, 10'd1, 1'b0);
    send(32'h10, 10'd2, 1'b0);
    send(32'h08, 10'd3, 1'b1);
    check_count(4'd2, 4'd3);
    drain_all();

    // Backpressure mid-drain, with an input offered while draining.
    push_both(32'h40, 10'd2, 1'b0);
    push_both(32'h50, 10'd4, 1'b0);
    push_both(32'h60, 10'd1, 1'b0);
    push_both(32'h70, 10'd3, 1'b1);
    send(32'h60, 10'd1, 1'b0);
    send(32'h40, 10'd2, 1'b0);
    send(32'h70, 10'd3, 1'b0);
    send(32'h50, 10'd4, 1'b1);
    out_ready = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    out_ready = 1'b0;
    in_valid = 1'b1; in_signature = 32'h01; in_index = 10'h3ff; in_last = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clock);
      chk("u0_drain_in_ready", 64'(ir[0]), 64'd0);
      chk("u1_drain_in_ready", 64'(ir[1]), 64'd0);
      @(posedge clock); #1;
    end
    in_valid = 1'b0; in_last = 1'b0;
    check_count(4'd4, 4'd4);
    drain_all();

    // Asynchronous reset partway through a frame.
    send(32'h11, 10'd1, 1'b0);
    send(32'h22, 10'd2, 1'b0);
    send(32'h33, 10'd3, 1'b0);
    send(32'h44, 10'd4, 1'b0);
    #2;
    reset = 1'b0;
    #1;
    check_count(4'd0, 4'd0);
    chk("u0_async_valid", 64'(ov[0]), 64'd0);
    chk("u1_async_valid", 64'(ov[1]), 64'd0);
    repeat (2) @(posedge clock);
    @(negedge clock) reset = 1'b1;
    @(posedge clock); #1;
    push_both(32'h07, 10'd9, 1'b1);
    send(32'h07, 10'd9, 1'b1);
    check_count(4'd1, 4'd1);
    drain_all();

    chk("u0_queue_empty", 64'(q0.size()), 64'd0);
    chk("u1_queue_empty", 64'(q1.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
